// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle LEGv8-style controller.
// Holds FSM states, opcode constants, ALU control codes and ALU B-source selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StAddr,
        StMemRd,
        StMemWr,
        StWbMem,
        StWbAlu,
        StExecMovz,
        StBranch,
        StError
    } state_t;

    typedef enum logic [2:0] {
        ClsR,
        ClsLoad,
        ClsStore,
        ClsCbz,
        ClsMovz,
        ClsIllegal
    } op_class_t;

    localparam logic [10:0] OpcAdd  = 11'b10001011000;
    localparam logic [10:0] OpcSub  = 11'b11001011000;
    localparam logic [10:0] OpcAnd  = 11'b10001010000;
    localparam logic [10:0] OpcOrr  = 11'b10101010000;
    localparam logic [10:0] OpcLdur = 11'b11111000010;
    localparam logic [10:0] OpcStur = 11'b11111000000;
    // CBZ and MOVZ are matched on their upper bits only.
    localparam logic [7:0]  OpcCbzPfx  = 8'b10110100;
    localparam logic [8:0]  OpcMovzPfx = 9'b110100101;

    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOrr   = 4'b0001;
    localparam logic [3:0] AluPassB = 4'b0111;

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier: instruction class, ALU operation and illegal flag
// from the 11-bit opcode field.
module mc_opdecode
    import mc_ctrl_pkg::*;
(
    input  logic [10:0] opcode_i,
    output op_class_t   op_class_o,
    output logic [3:0]  alu_code_o,
    output logic        illegal_o
);

    always_comb begin
        op_class_o = ClsIllegal;
        alu_code_o = AluAdd;
        case (opcode_i)
            OpcAdd:  op_class_o = ClsR;
            OpcSub: begin
                op_class_o = ClsR;
                alu_code_o = AluSub;
            end
            OpcAnd: begin
                op_class_o = ClsR;
                alu_code_o = AluAnd;
            end
            OpcOrr: begin
                op_class_o = ClsR;
                alu_code_o = AluOrr;
            end
            OpcLdur: op_class_o = ClsLoad;
            OpcStur: op_class_o = ClsStore;
            default: begin
                if (opcode_i[10:3] == OpcCbzPfx) begin
                    op_class_o = ClsCbz;
                    alu_code_o = AluPassB;
                end else if (opcode_i[10:2] == OpcMovzPfx) begin
                    op_class_o = ClsMovz;
                    alu_code_o = AluPassB;
                end
            end
        endcase
    end

    assign illegal_o = (op_class_o == ClsIllegal);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: FETCH/DECODE/execute FSM with a memory-wait
// timeout counter and a sticky error state left only through reset.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg2loc,
    output logic        mem_to_reg,
    output logic        movz,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic        error
);

    localparam logic [7:0] CntLast = 8'(MEM_TIMEOUT - 1);

    state_t    state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    op_class_t cls_q, cls_d;
    logic [3:0] alu_q, alu_d;
    logic       mem_wait;

    op_class_t  dec_class;
    logic [3:0] dec_alu;
    logic       dec_illegal;

    mc_opdecode u_opdecode (
        .opcode_i   (instr),
        .op_class_o (dec_class),
        .alu_code_o (dec_alu),
        .illegal_o  (dec_illegal)
    );

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        alu_d    = alu_q;
        mem_wait = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_wait = 1'b1;
                if (mem_ready)               state_d = StDecode;
                else if (cnt_q == CntLast)   state_d = StError;
            end
            StDecode: begin
                // Latch the classification so later states need not re-decode instr.
                cls_d = dec_class;
                alu_d = dec_alu;
                if (dec_illegal) begin
                    state_d = StError;
                end else begin
                    case (dec_class)
                        ClsR:              state_d = StExecR;
                        ClsLoad, ClsStore: state_d = StAddr;
                        ClsCbz:            state_d = StBranch;
                        ClsMovz:           state_d = StExecMovz;
                        default:           state_d = StError;
                    endcase
                end
            end
            StExecR:    state_d = StWbAlu;
            StAddr:     state_d = (cls_q == ClsLoad) ? StMemRd : StMemWr;
            StMemRd: begin
                mem_wait = 1'b1;
                if (mem_ready)               state_d = StWbMem;
                else if (cnt_q == CntLast)   state_d = StError;
            end
            StMemWr: begin
                mem_wait = 1'b1;
                if (mem_ready)               state_d = StFetch;
                else if (cnt_q == CntLast)   state_d = StError;
            end
            StWbMem, StWbAlu, StBranch: state_d = StFetch;
            StExecMovz: state_d = StWbAlu;
            StError:    state_d = StError;
            default:    state_d = StError;
        endcase

        // Any state change counts as entry, so the counter starts at 0 in each wait state.
        if (state_d != state_q)           cnt_d = 8'd0;
        else if (mem_wait && !mem_ready)  cnt_d = cnt_q + 8'd1;
        else                              cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= 8'd0;
            cls_q   <= ClsIllegal;
            alu_q   <= AluAdd;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
        end
    end

    // Outputs are forced low while reset is high, so an abandoned access strobes nothing.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg2loc     = 1'b0;
        mem_to_reg  = 1'b0;
        movz        = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SrcBReg;
        alu_control = 4'b0000;
        error       = 1'b0;
        if (!reset) begin
            alu_control = AluAdd;
            unique case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = SrcBFour;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: ;
                StExecR: begin
                    alu_src_a   = 1'b1;
                    alu_control = alu_q;
                end
                StAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SrcBImm;
                end
                StMemRd: mem_read = 1'b1;
                StMemWr: begin
                    mem_write = 1'b1;
                    reg2loc   = 1'b1;
                end
                StWbMem: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StWbAlu: begin
                    reg_write = 1'b1;
                    movz      = (cls_q == ClsMovz);
                end
                StExecMovz: begin
                    alu_src_b   = SrcBImm;
                    alu_control = AluPassB;
                    movz        = 1'b1;
                end
                StBranch: begin
                    reg2loc     = 1'b1;
                    alu_src_a   = 1'b1;
                    alu_control = AluPassB;
                    pc_src      = zero;
                    pc_write    = zero;
                end
                StError: error = 1'b1;
                default: error = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; outputs are packed into one
// vector and compared cycle by cycle against hand-written per-state values.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic        reg2loc, mem_to_reg, movz, pc_src, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic        error;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg2loc     (reg2loc),
        .mem_to_reg  (mem_to_reg),
        .movz        (movz),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .error       (error)
    );

    always #5 clk = ~clk;

    // {pc_write ir_write mem_read mem_write reg_write reg2loc mem_to_reg movz pc_src
    //  alu_src_a} _ alu_src_b _ alu_control _ error
    logic [16:0] obs;
    assign obs = {pc_write, ir_write, mem_read, mem_write, reg_write, reg2loc, mem_to_reg,
                  movz, pc_src, alu_src_a, alu_src_b, alu_control, error};

    localparam logic [16:0] VZero  = 17'b0;
    localparam logic [16:0] VFWait = 17'b0010000000_01_0010_0;
    localparam logic [16:0] VFGo   = 17'b1110000000_01_0010_0;
    localparam logic [16:0] VDec   = 17'b0000000000_00_0010_0;
    localparam logic [16:0] VXAdd  = 17'b0000000001_00_0010_0;
    localparam logic [16:0] VXSub  = 17'b0000000001_00_0110_0;
    localparam logic [16:0] VXAnd  = 17'b0000000001_00_0000_0;
    localparam logic [16:0] VXOrr  = 17'b0000000001_00_0001_0;
    localparam logic [16:0] VAddr  = 17'b0000000001_10_0010_0;
    localparam logic [16:0] VMRd   = 17'b0010000000_00_0010_0;
    localparam logic [16:0] VMWr   = 17'b0001010000_00_0010_0;
    localparam logic [16:0] VWbM   = 17'b0000101000_00_0010_0;
    localparam logic [16:0] VWbA   = 17'b0000100000_00_0010_0;
    localparam logic [16:0] VWbAZ  = 17'b0000100100_00_0010_0;
    localparam logic [16:0] VXMovz = 17'b0000000100_10_0111_0;
    localparam logic [16:0] VBrT   = 17'b1000010011_00_0111_0;
    localparam logic [16:0] VBrN   = 17'b0000010001_00_0111_0;
    localparam logic [16:0] VErr   = 17'b0000000000_00_0010_1;

    localparam logic [10:0] IAdd  = 11'b10001011000;
    localparam logic [10:0] ISub  = 11'b11001011000;
    localparam logic [10:0] IAnd  = 11'b10001010000;
    localparam logic [10:0] IOrr  = 11'b10101010000;
    localparam logic [10:0] ILdur = 11'b11111000010;
    localparam logic [10:0] IStur = 11'b11111000000;
    localparam logic [10:0] ICbz  = 11'b10110100101;
    localparam logic [10:0] IMovz = 11'b11010010110;

    // Ends on a falling edge with reset just released: the DUT sits in FETCH.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b1;
        instr = IAdd;
        #1;
        checks++;
        if (obs !== VZero) begin
            failures++;
            $display("FAIL reset_t0 got=%b want=%b", obs, VZero);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs !== VZero) begin
            failures++;
            $display("FAIL reset_held got=%b want=%b", obs, VZero);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        #1;
        checks++;
        if (obs !== VFWait) begin
            failures++;
            $display("FAIL reset_release_fetch got=%b want=%b", obs, VFWait);
        end
        @(negedge clk);
    endtask

    task automatic test_r_type();
        logic [10:0] ops [4];
        logic [16:0] xv [4];
        logic [16:0] ex [4];
        int rw_cnt;
        ops = '{IAdd, ISub, IAnd, IOrr};
        xv  = '{VXAdd, VXSub, VXAnd, VXOrr};
        for (int k = 0; k < 4; k++) begin
            instr = ops[k];
            ex = '{VFGo, VDec, xv[k], VWbA};
            rw_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1;
                #1;
                if (reg_write) rw_cnt++;
                checks++;
                if (obs !== ex[i]) begin
                    failures++;
                    $display("FAIL rtype op%0d cyc%0d got=%b want=%b", k, i, obs, ex[i]);
                end
                @(negedge clk);
            end
            checks++;
            if (rw_cnt !== 1) begin
                failures++;
                $display("FAIL rtype_reg_write_once op%0d got=%0d want=1", k, rw_cnt);
            end
        end
    endtask

    task automatic test_movz();
        logic [16:0] ex [4];
        ex = '{VFGo, VDec, VXMovz, VWbAZ};
        instr = IMovz;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL movz cyc%0d got=%b want=%b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ldur();
        logic [16:0] ex [7];
        logic        rdy [7];
        ex  = '{VFGo, VDec, VAddr, VMRd, VMRd, VMRd, VWbM};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        instr = ILdur;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL ldur_wait cyc%0d got=%b want=%b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stur();
        logic [16:0] ex [5];
        logic        rdy [5];
        ex  = '{VFGo, VDec, VAddr, VMWr, VFWait};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        instr = IStur;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL stur cyc%0d got=%b want=%b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cbz();
        logic [16:0] ex [7];
        logic        rdy [7];
        logic        zr [7];
        ex  = '{VFGo, VDec, VBrT, VFGo, VDec, VBrN, VFWait};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        zr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        instr = ICbz;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            zero = zr[i];
            #1;
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL cbz cyc%0d got=%b want=%b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [16:0] want;
        instr = 11'b00000000000;
        for (int i = 0; i < 12; i++) begin
            mem_ready = (i == 0) ? 1'b1 : i[0];
            want = (i == 0) ? VFGo : (i == 1) ? VDec : VErr;
            #1;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%b want=%b", i, obs, want);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== VZero) begin
            failures++;
            $display("FAIL illegal_reset_clear got=%b want=%b", obs, VZero);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== VFWait) begin
            failures++;
            $display("FAIL illegal_after_reset got=%b want=%b", obs, VFWait);
        end
        @(negedge clk);
    endtask

    task automatic test_fetch_timeout();
        logic [16:0] want;
        instr = IAdd;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem_ready = 1'b0;
            want = (i < 15) ? VFWait : VErr;
            #1;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL fetch_timeout cyc%0d got=%b want=%b", i, obs, want);
            end
            @(negedge clk);
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem_ready = (i == 14);
            want = (i < 14) ? VFWait : (i == 14) ? VFGo : VDec;
            #1;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL fetch_last_chance cyc%0d got=%b want=%b", i, obs, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_memrd_timeout();
        logic [16:0] want;
        instr = ILdur;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            mem_ready = (i == 3);
            if (i < 3)       want = VFWait;
            else if (i == 3) want = VFGo;
            else if (i == 4) want = VDec;
            else if (i == 5) want = VAddr;
            else if (i < 21) want = VMRd;
            else             want = VErr;
            #1;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL memrd_timeout cyc%0d got=%b want=%b", i, obs, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_memwr();
        logic [16:0] ex [4];
        ex = '{VFGo, VDec, VAddr, VMWr};
        instr = IStur;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            #1;
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL memwr_pre cyc%0d got=%b want=%b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs !== VZero) begin
                failures++;
                $display("FAIL memwr_reset cyc%0d got=%b want=%b", i, obs, VZero);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== VFWait) begin
            failures++;
            $display("FAIL memwr_release got=%b want=%b", obs, VFWait);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_movz();
        test_ldur();
        test_stur();
        test_cbz();
        test_illegal();
        test_fetch_timeout();
        test_memrd_timeout();
        test_reset_in_memwr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
